// File: rtl/sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sr_drive_ctrl
// Description : Debounces set/reset push-buttons and issues clean, gapped,
//               arbitrated s/r pulses to an SR latch stage.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_drive_ctrl #(
    parameter int DEB_CYCLES   = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic q_exp
);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_PULSE_S = 3'd2,
        ST_PULSE_R = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_PULSE_LAST = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

    logic [1:0] raw;       // bit 0 = set, bit 1 = reset
    logic [1:0] deb_rise;

    assign raw = {rst_req, set_req};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_cond
        logic             sync1_q, sync2_q, deb_q, deb_prev_q;
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
                cnt_q      <= '0;
            end else begin
                sync1_q    <= raw[gi];
                sync2_q    <= sync1_q;
                deb_prev_q <= deb_q;
                if (sync2_q == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == c_DEB_LAST) begin
                    deb_q <= ~deb_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + c_ONE;
                end
            end
        end

        assign deb_rise[gi] = deb_q & ~deb_prev_q;
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_s_q, pend_s_d, pend_r_q, pend_r_d;
    logic             s_q, s_d, r_q, r_d, busy_q, busy_d;
    logic             conflict_q, conflict_d, q_exp_q, q_exp_d;
    logic             take_s, take_r;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_exp_d = q_exp_q;
        take_s  = 1'b0;
        take_r  = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_PULSE_R;
                cnt_d   = c_ONE;
            end
            ST_IDLE: begin
                if (pend_r_q) begin
                    state_d = ST_PULSE_R;
                    cnt_d   = c_ONE;
                    take_r  = 1'b1;
                end else if (pend_s_q) begin
                    state_d = ST_PULSE_S;
                    cnt_d   = c_ONE;
                    take_s  = 1'b1;
                end
            end
            ST_PULSE_S, ST_PULSE_R: begin
                if (cnt_q == c_PULSE_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = c_ONE;
                    q_exp_d = (state_q == ST_PULSE_S);
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == c_GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A fresh request on the serving clock re-arms the flag rather than being lost.
        pend_s_d = pend_s_q & ~take_s;
        pend_r_d = pend_r_q & ~take_r;
        if (deb_rise[1])
            pend_r_d = 1'b1;
        else if (deb_rise[0])
            pend_s_d = 1'b1;
        conflict_d = deb_rise[0] & deb_rise[1];

        s_d    = (state_d == ST_PULSE_S);
        r_d    = (state_d == ST_PULSE_R);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            pend_s_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            q_exp_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_s_q   <= pend_s_d;
            pend_r_q   <= pend_r_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
            q_exp_q    <= q_exp_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
    assign q_exp    = q_exp_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_drive_ctrl
// Description : Vector-table bench for sr_drive_ctrl with per-cycle scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_drive_ctrl;

    localparam int DEB   = 4;
    localparam int PULSE = 2;
    localparam int GAP   = 1;
    localparam int LAT   = DEB + 3;
    localparam int K     = 6;
    localparam int NCYC  = 30;
    localparam int NVEC  = 12;

    logic clk, rst_n, set_req, rst_req;
    logic s, r, busy, conflict, q_exp;

    sr_drive_ctrl #(
        .DEB_CYCLES  (DEB),
        .PULSE_CYCLES(PULSE),
        .GAP_CYCLES  (GAP),
        .CNT_W       (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_req (set_req),
        .rst_req (rst_req),
        .s       (s),
        .r       (r),
        .busy    (busy),
        .conflict(conflict),
        .q_exp   (q_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int set_k;
        int set_len;
        bit set_tog;
        int rst_k;
        int rst_len;
        int p1;
        bit p1_s;
        int p2;
        bit p2_s;
        int conf_at;
        int kill_at;
    } vec_t;

    typedef struct {
        bit s;
        bit r;
        bit busy;
        bit conf;
        bit q;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sbq [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(int sk, int sl, bit tg, int rk, int rl,
                                int p1, bit p1s, int p2, bit p2s, int cf, int kl);
        vec_t v;
        v.set_k = sk;  v.set_len = sl; v.set_tog = tg;
        v.rst_k = rk;  v.rst_len = rl;
        v.p1 = p1;     v.p1_s = p1s;
        v.p2 = p2;     v.p2_s = p2s;
        v.conf_at = cf; v.kill_at = kl;
        return v;
    endfunction

    // Expected outputs after edge t, built from the pulse start times in the table;
    // the INIT-forced reset pulse always starts at edge 1.
    function automatic exp_t model(vec_t v, int t);
        exp_t e;
        int   st [3];
        bit   ty [3];
        st[0] = 1;    ty[0] = 1'b0;
        st[1] = v.p1; ty[1] = v.p1_s;
        st[2] = v.p2; ty[2] = v.p2_s;
        e.s = 1'b0; e.r = 1'b0; e.busy = 1'b0; e.q = 1'b0;
        e.conf = (t == v.conf_at);
        for (int i = 0; i < 3; i++) begin
            if (st[i] > 0 && t >= st[i]) begin
                if (t < st[i] + PULSE) begin
                    if (ty[i]) e.s = 1'b1;
                    else       e.r = 1'b1;
                end
                if (t < st[i] + PULSE + GAP) e.busy = 1'b1;
                if (t >= st[i] + PULSE)      e.q = ty[i];
            end
        end
        return e;
    endfunction

    task automatic chk(string nm, int vi, int t, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d t=%0d got=%b expected=%b", nm, vi, t, act, exp);
        end
    endtask

    task automatic run_vec(int vi);
        vec_t v;
        exp_t e;
        bit   stop;
        v = vecs[vi];
        rst_n   = 1'b0;
        set_req = 1'b0;
        rst_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s",    vi, 0, s,        1'b0);
        chk("rst_r",    vi, 0, r,        1'b0);
        chk("rst_busy", vi, 0, busy,     1'b0);
        chk("rst_conf", vi, 0, conflict, 1'b0);
        chk("rst_q",    vi, 0, q_exp,    1'b0);
        rst_n = 1'b1;
        stop  = 1'b0;
        for (int t = 1; t <= NCYC && !stop; t++) begin
            if (t >= v.set_k && t < v.set_k + v.set_len)
                set_req = v.set_tog ? (((t - v.set_k) % 2) == 0) : 1'b1;
            else
                set_req = 1'b0;
            rst_req = (t >= v.rst_k && t < v.rst_k + v.rst_len);
            sbq.push_back(model(v, t));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            chk("s",        vi, t, s,        e.s);
            chk("r",        vi, t, r,        e.r);
            chk("busy",     vi, t, busy,     e.busy);
            chk("conflict", vi, t, conflict, e.conf);
            chk("q_exp",    vi, t, q_exp,    e.q);
            chk("s_and_r",  vi, t, s & r,    1'b0);
            if (t == v.kill_at) begin
                #1 rst_n = 1'b0;
                #1;
                chk("kill_s",    vi, t, s,     1'b0);
                chk("kill_r",    vi, t, r,     1'b0);
                chk("kill_busy", vi, t, busy,  1'b0);
                chk("kill_q",    vi, t, q_exp, 1'b0);
                stop = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        set_req = 1'b0;
        rst_req = 1'b0;
        //               set_k  len  tog rst_k len  p1       p1s  p2                      p2s  conf       kill
        vecs[0]  = mk(0,     0,   0,  0,    0,   0,       0,   0,                      0,   0,         0);
        vecs[1]  = mk(K,     10,  0,  0,    0,   K+LAT,   1,   0,                      0,   0,         0);
        vecs[2]  = mk(0,     0,   0,  K,    10,  K+LAT,   0,   0,                      0,   0,         0);
        vecs[3]  = mk(K,     20,  1,  0,    0,   0,       0,   0,                      0,   0,         0);
        vecs[4]  = mk(K,     10,  0,  K,    10,  K+LAT,   0,   0,                      0,   K+LAT-1,   0);
        vecs[5]  = mk(K,     DEB-1, 0, 0,   0,   0,       0,   0,                      0,   0,         0);
        vecs[6]  = mk(K,     DEB, 0,  0,    0,   K+LAT,   1,   0,                      0,   0,         0);
        vecs[7]  = mk(K+2,   10,  0,  K,    10,  K+LAT,   0,   K+LAT+PULSE+GAP+1,      1,   0,         0);
        vecs[8]  = mk(K,     10,  0,  K+3,  10,  K+LAT,   1,   K+LAT+PULSE+GAP+1,      0,   0,         0);
        vecs[9]  = mk(K+1,   10,  0,  K,    10,  K+LAT,   0,   K+LAT+PULSE+GAP+1,      1,   0,         0);
        vecs[10] = mk(K,     DEB, 0,  0,    0,   K+LAT,   1,   0,                      0,   0,         K+LAT);
        vecs[11] = mk(0,     0,   0,  0,    0,   0,       0,   0,                      0,   0,         0);
        for (int i = 0; i < NVEC; i++)
            run_vec(i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
